digit_entry_writer: RTL and testbench
=====================================

DIGIT_ENTRY_WRITER -- requirements
Module: digit_entry_writer

Interface
REQ-001 Parameter VSYNC_ACTIVE_LOW, default 1, meaning vga_v_sync is low during the sync pulse.
REQ-002 Parameter MAX_DIGITS, fixed at 4, meaning digit capacity of the 16-bit BCD word; other values are unsupported.
REQ-003 clk  input  1  the single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 key_valid  input  1  key_code holds a valid key event.
REQ-006 key_code  input  5  key value: 0x00-0x09 digit, 0x10 backspace, 0x11 clear, 0x12 enter; all others invalid.
REQ-007 key_ready  output  1  block accepts a key this cycle.
REQ-008 vga_v_sync  input  1  vertical sync from the VGA timing generator, possibly asynchronous.
REQ-009 numbers  output  16  BCD display word; nibble k holds display column k, with column 0 leftmost.
REQ-010 value  output  16  last committed BCD entry.
REQ-011 value_valid  output  1  one-cycle pulse when value is updated.
REQ-012 digit_count  output  3  number of digits in the working buffer, 0-4.
REQ-013 key_error  output  1  one-cycle pulse on a rejected key.

Function
REQ-014 Handshake: a key SHALL transfer on a rising edge where key_valid and key_ready are both 1; key_code is sampled only on that edge.
REQ-015 key_ready SHALL be 1 only in state IDLE, decoded directly from the state register.
REQ-016 FSM: states are IDLE, EXEC and COMMIT.
- IDLE -> EXEC on a transfer.
- EXEC -> COMMIT when the key is enter; otherwise EXEC -> IDLE.
- COMMIT -> IDLE unconditionally.
REQ-017 The working buffer (shadow, 16 bits) and digit_count SHALL be modified only on the edge that leaves EXEC.
REQ-018 Digit key with digit_count < 4: shadow nibble [digit_count] <= key_code[3:0]; digit_count increments.
REQ-019 Digit key with digit_count = 4: shadow is unchanged and key_error pulses for one cycle.
REQ-020 Backspace with digit_count > 0: digit_count decrements and nibble [digit_count-1] is cleared to 0.
REQ-021 Backspace with digit_count = 0: no change, and no error is flagged.
REQ-022 Clear: shadow <= 0 and digit_count <= 0.
REQ-023 Enter, on the EXEC exit edge: value <= shadow, value_valid <= 1, shadow <= 0, digit_count <= 0. An empty buffer commits 0x0000.
REQ-024 On the COMMIT exit edge, value_valid <= 0. value_valid is therefore high for exactly one cycle.
REQ-025 Invalid key_code (0x0A-0x0F, 0x13-0x1F): the key is consumed, shadow is unchanged, and key_error pulses for one cycle coincident with the EXEC exit.
REQ-026 Timing for a transfer at edge N:
- the shadow update is visible after edge N+1;
- key_ready returns high after edge N+1 (non-enter keys) or after edge N+2 (enter).
REQ-027 vga_v_sync SHALL pass through a 2-flop synchronizer followed by an edge detector. The sync-start edge is the falling edge when VSYNC_ACTIVE_LOW=1, otherwise the rising edge.
REQ-028 numbers <= shadow only on the cycle the synchronized sync-start edge is detected; numbers SHALL NOT change at any other time.
REQ-029 If the sync-start detection and a shadow update occur on the same edge, numbers takes the pre-update shadow; the new content appears at the next frame.
REQ-030 key_valid deasserting while key_ready is 0 SHALL have no effect; key_valid is never latched outside a transfer.

Reset
REQ-031 While reset is 1, the following SHALL be forced asynchronously:
- state = IDLE;
- shadow, numbers and value = 0x0000;
- digit_count = 0; value_valid and key_error = 0;
- both synchronizer flops = the inactive sync level.
REQ-032 key_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-033 Reset asserted in EXEC or COMMIT SHALL abort the pending operation; no value_valid pulse follows reset.

Verification
REQ-034 Keys 1,2,3 with a vsync pulse after each EXEC -> numbers = 0x0321 and digit_count = 3; then enter -> value = 0x0321, a single value_valid pulse, digit_count = 0; next vsync -> numbers = 0x0000.
REQ-035 Keys 9,8,7,6,5 -> the fifth key raises key_error, digit_count stays 4, and numbers = 0x6789 after vsync.
REQ-036 Keys 4,5, backspace, backspace, backspace -> digit_count reads 1, 0, 0 after the three backspaces, with no key_error.
REQ-037 A digit accepted with its EXEC exit coinciding with detected sync-start -> numbers keeps its old value; it updates at the next vsync.
REQ-038 key_valid held high continuously -> exactly one transfer per 2 cycles (3 for enter); key_code 0x0C -> key_error pulse with no state change.
REQ-039 Reset asserted mid-EXEC on an enter key -> no value_valid pulse, value = 0x0000, key_ready = 1 after release.

Source files
------------

// File: rtl/digit_entry_writer.sv
// Digit entry writer: accepts keypad events through a valid/ready handshake,
// builds a BCD working buffer of up to four digits, commits it on enter, and
// copies the buffer to the display word only at the start of a vertical sync.
module digit_entry_writer #(
    parameter int VSYNC_ACTIVE_LOW = 1,
    parameter int MAX_DIGITS       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        key_ready,
    input  logic        vga_v_sync,
    output logic [15:0] numbers,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [2:0]  digit_count,
    output logic        key_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic SYNC_IDLE_LEVEL = (VSYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [4:0] KEY_BACKSPACE = 5'h10;
    localparam logic [4:0] KEY_CLEAR     = 5'h11;
    localparam logic [4:0] KEY_ENTER     = 5'h12;

    state_t      state_r;
    logic [4:0]  op_code_r;
    logic [15:0] shadow_r;

    logic [15:0] shadow_next_s;
    logic [2:0]  count_next_s;
    logic        error_next_s;
    logic        commit_s;

    logic        vs_meta_r;
    logic        vs_sync_r;
    logic        vs_prev_r;
    logic        sync_start_s;

    // Ready is a pure decode of the state register, so it cannot glitch on key_valid.
    assign key_ready = (state_r == IDLE);

    // Work out the buffer contents that the latched key produces when EXEC retires.
    always_comb begin
        shadow_next_s = shadow_r;
        count_next_s  = digit_count;
        error_next_s  = 1'b0;
        commit_s      = 1'b0;
        if ((op_code_r[4] == 1'b0) && (op_code_r[3:0] <= 4'd9)) begin
            if (digit_count < 3'(MAX_DIGITS)) begin
                for (int k = 0; k < 4; k++) begin
                    if (digit_count == 3'(k)) begin
                        shadow_next_s[4*k +: 4] = op_code_r[3:0];
                    end else begin
                        shadow_next_s[4*k +: 4] = shadow_next_s[4*k +: 4];
                    end
                end
                count_next_s = digit_count + 3'd1;
            end else begin
                // Buffer full: the digit is dropped and flagged.
                error_next_s = 1'b1;
            end
        end else begin
            case (op_code_r)
                KEY_BACKSPACE: begin
                    if (digit_count != 3'd0) begin
                        for (int k = 0; k < 4; k++) begin
                            if (digit_count == 3'(k + 1)) begin
                                shadow_next_s[4*k +: 4] = 4'h0;
                            end else begin
                                shadow_next_s[4*k +: 4] = shadow_next_s[4*k +: 4];
                            end
                        end
                        count_next_s = digit_count - 3'd1;
                    end else begin
                        // Backspace on an empty buffer is silently ignored.
                        count_next_s = 3'd0;
                    end
                end
                KEY_CLEAR: begin
                    shadow_next_s = 16'h0000;
                    count_next_s  = 3'd0;
                end
                KEY_ENTER: begin
                    shadow_next_s = 16'h0000;
                    count_next_s  = 3'd0;
                    commit_s      = 1'b1;
                end
                default: begin
                    error_next_s = 1'b1;
                end
            endcase
        end
    end

    // Handshake FSM plus the working buffer, commit register and pulse outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            op_code_r   <= 5'h00;
            shadow_r    <= 16'h0000;
            digit_count <= 3'd0;
            value       <= 16'h0000;
            value_valid <= 1'b0;
            key_error   <= 1'b0;
        end else begin
            key_error <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (key_valid) begin
                        op_code_r <= key_code;
                        state_r   <= EXEC;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                EXEC: begin
                    shadow_r    <= shadow_next_s;
                    digit_count <= count_next_s;
                    key_error   <= error_next_s;
                    if (commit_s) begin
                        value       <= shadow_r;
                        value_valid <= 1'b1;
                        state_r     <= COMMIT;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                COMMIT: begin
                    value_valid <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    value_valid <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Detect the synchronized sync-start transition from the previous sample.
    always_comb begin
        if (VSYNC_ACTIVE_LOW != 0) begin
            sync_start_s = vs_prev_r & ~vs_sync_r;
        end else begin
            sync_start_s = ~vs_prev_r & vs_sync_r;
        end
    end

    // Resynchronize vsync and latch the display word once per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_meta_r <= SYNC_IDLE_LEVEL;
            vs_sync_r <= SYNC_IDLE_LEVEL;
            vs_prev_r <= SYNC_IDLE_LEVEL;
            numbers   <= 16'h0000;
        end else begin
            vs_meta_r <= vga_v_sync;
            vs_sync_r <= vs_meta_r;
            vs_prev_r <= vs_sync_r;
            // shadow_r here is the pre-update value when an EXEC exit coincides.
            if (sync_start_s) begin
                numbers <= shadow_r;
            end else begin
                numbers <= numbers;
            end
        end
    end

endmodule

// File: tb/tb_digit_entry_writer.sv
// Self-checking bench for digit_entry_writer: directed scenarios followed by
// randomized key traffic checked against a queue-based model of the entry buffer.
module tb_digit_entry_writer;

    logic        clk;
    logic        reset;
    logic        key_valid;
    logic [4:0]  key_code;
    logic        key_ready;
    logic        vga_v_sync;
    logic [15:0] numbers;
    logic [15:0] value;
    logic        value_valid;
    logic [2:0]  digit_count;
    logic        key_error;

    int checks = 0;
    int errors = 0;

    // Reference model state: entered digits in order, committed value, displayed word.
    int          digits[$];
    logic [15:0] m_value;
    logic [15:0] m_numbers;

    digit_entry_writer dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .vga_v_sync (vga_v_sync),
        .numbers    (numbers),
        .value      (value),
        .value_valid(value_valid),
        .digit_count(digit_count),
        .key_error  (key_error)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_shadow();
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < digits.size(); i++) begin
            s = s + (16'(digits[i]) << (4 * i));
        end
        return s;
    endfunction

    function automatic void model_key(input logic [4:0] c, output logic err, output logic ent);
        err = 1'b0;
        ent = 1'b0;
        if (c <= 5'h09) begin
            if (digits.size() < 4) digits.push_back(int'(c));
            else err = 1'b1;
        end else if (c == 5'h10) begin
            if (digits.size() > 0) void'(digits.pop_back());
        end else if (c == 5'h11) begin
            digits.delete();
        end else if (c == 5'h12) begin
            ent = 1'b1;
            m_value = model_shadow();
            digits.delete();
        end else begin
            err = 1'b1;
        end
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [4:0] code);
        logic exp_err;
        logic ent;
        int   n;
        n = 0;
        while (key_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("ready_before", {31'd0, key_ready}, 32'd1);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        // Junk on the inputs while busy must be ignored.
        key_valid = 1'($urandom_range(0, 1));
        key_code  = 5'($urandom);
        check("ready_in_exec", {31'd0, key_ready}, 32'd0);
        model_key(code, exp_err, ent);
        tick();
        key_valid = 1'b0;
        check("key_error", {31'd0, key_error}, {31'd0, exp_err});
        check("digit_count", {29'd0, digit_count}, 32'(digits.size()));
        check("value_valid", {31'd0, value_valid}, {31'd0, ent});
        check("numbers_hold", {16'd0, numbers}, {16'd0, m_numbers});
        if (ent) begin
            check("value", {16'd0, value}, {16'd0, m_value});
            check("ready_in_commit", {31'd0, key_ready}, 32'd0);
            tick();
            check("value_valid_end", {31'd0, value_valid}, 32'd0);
        end
        check("ready_after", {31'd0, key_ready}, 32'd1);
    endtask

    task automatic vsync_frame();
        vga_v_sync = 1'b0;
        repeat (4) tick();
        m_numbers = model_shadow();
        vga_v_sync = 1'b1;
        repeat (4) tick();
        check("numbers_frame", {16'd0, numbers}, {16'd0, m_numbers});
    endtask

    initial begin
        logic [4:0] codes[5];
        logic       e_unused;
        logic       n_unused;
        int         idx;
        int         last_t;
        int         exp_gap;
        int         errs;
        int         vv;
        logic [15:0] old_num;
        int          r;
        logic [4:0]  c;

        reset      = 1'b1;
        key_valid  = 1'b0;
        key_code   = 5'h00;
        vga_v_sync = 1'b1;
        m_value    = 16'h0000;
        m_numbers  = 16'h0000;
        repeat (3) tick();
        check("rst_numbers", {16'd0, numbers}, 32'd0);
        check("rst_value", {16'd0, value}, 32'd0);
        check("rst_value_valid", {31'd0, value_valid}, 32'd0);
        check("rst_count", {29'd0, digit_count}, 32'd0);
        check("rst_key_error", {31'd0, key_error}, 32'd0);
        reset = 1'b0;
        tick();
        check("ready_after_reset", {31'd0, key_ready}, 32'd1);

        // Keys 1,2,3 with a frame after each, then enter and a final frame.
        send_key(5'h01); vsync_frame();
        send_key(5'h02); vsync_frame();
        send_key(5'h03); vsync_frame();
        check("seq123_numbers", {16'd0, numbers}, 32'h0321);
        send_key(5'h12);
        check("seq123_value", {16'd0, value}, 32'h0321);
        vsync_frame();
        check("seq123_cleared", {16'd0, numbers}, 32'h0000);

        // Overflow: the fifth digit is rejected.
        send_key(5'h09); send_key(5'h08); send_key(5'h07); send_key(5'h06);
        send_key(5'h05);
        vsync_frame();
        check("overflow_numbers", {16'd0, numbers}, 32'h6789);
        send_key(5'h11);

        // Backspace down to and past empty.
        send_key(5'h04); send_key(5'h05);
        send_key(5'h10); send_key(5'h10); send_key(5'h10);
        vsync_frame();

        // Digit whose EXEC exit coincides with sync-start detection.
        old_num = m_numbers;
        vga_v_sync = 1'b0;
        tick();
        key_valid = 1'b1;
        key_code  = 5'h07;
        tick();
        key_valid = 1'b0;
        model_key(5'h07, e_unused, n_unused);
        tick();
        check("race_numbers_old", {16'd0, numbers}, {16'd0, old_num});
        check("race_count", {29'd0, digit_count}, 32'(digits.size()));
        vga_v_sync = 1'b1;
        repeat (4) tick();
        check("race_numbers_still_old", {16'd0, numbers}, {16'd0, old_num});
        vsync_frame();
        check("race_numbers_new", {16'd0, numbers}, 32'h0007);

        // key_valid held high: one transfer per 2 cycles, 3 for enter.
        send_key(5'h11);
        codes = '{5'h01, 5'h02, 5'h12, 5'h0C, 5'h03};
        idx = 0; last_t = -1; exp_gap = 0; errs = 0; vv = 0;
        for (int t = 0; t < 30; t++) begin
            if (key_error === 1'b1) errs++;
            if (value_valid === 1'b1) vv++;
            if (key_ready === 1'b1) begin
                if (idx < 5) begin
                    if (last_t >= 0) check("stream_gap", 32'(t - last_t), 32'(exp_gap));
                    key_valid = 1'b1;
                    key_code  = codes[idx];
                    model_key(codes[idx], e_unused, n_unused);
                    exp_gap = (codes[idx] == 5'h12) ? 3 : 2;
                    last_t = t;
                    idx++;
                end else begin
                    key_valid = 1'b0;
                end
            end
            tick();
        end
        key_valid = 1'b0;
        check("stream_keys", 32'(idx), 32'd5);
        check("stream_errors", 32'(errs), 32'd1);
        check("stream_commits", 32'(vv), 32'd1);
        check("stream_value", {16'd0, value}, 32'h0021);
        check("stream_count", {29'd0, digit_count}, 32'(digits.size()));
        vsync_frame();

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      c = 5'($urandom_range(0, 9));
            else if (r < 75) c = 5'h10;
            else if (r < 80) c = 5'h11;
            else if (r < 90) c = 5'h12;
            else if (r < 95) c = 5'($urandom_range(10, 15));
            else             c = 5'($urandom_range(19, 31));
            send_key(c);
            if ($urandom_range(0, 5) == 0) vsync_frame();
        end
        vsync_frame();

        // Reset while an enter sits in EXEC aborts the commit.
        send_key(5'h11);
        send_key(5'h05);
        key_valid = 1'b1;
        key_code  = 5'h12;
        tick();
        key_valid = 1'b0;
        reset = 1'b1;
        #2;
        check("abort_value", {16'd0, value}, 32'h0000);
        check("abort_value_valid", {31'd0, value_valid}, 32'd0);
        tick();
        reset = 1'b0;
        digits.delete();
        m_numbers = 16'h0000;
        m_value   = 16'h0000;
        tick();
        check("abort_ready", {31'd0, key_ready}, 32'd1);
        vv = 0;
        repeat (4) begin
            if (value_valid !== 1'b0) vv++;
            tick();
        end
        check("abort_no_pulse", 32'(vv), 32'd0);
        check("abort_count", {29'd0, digit_count}, 32'd0);
        check("abort_numbers", {16'd0, numbers}, 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
